// File: rtl/pulse_meter.sv
// Purpose: counts stepper pulses (running total) and steps per 1 s gate window, both as packed BCD.
// Latency: pulse_in rising edge -> total_bcd update in SYNC_STAGES+2 clk; gate edge -> freq_valid in SYNC_STAGES+2 clk.
// Backpressure: none; free-running observer, every detected edge is consumed in the cycle it is seen.
//
// Ports: clk, rst (async, active-low); pulse_in/gate_in/count_en are asynchronous and re-synchronised;
//        clear is a synchronous level. Outputs: total_bcd (TOT_DIGITS BCD digits, LSD in [3:0]),
//        freq_bcd (3 BCD digits), freq_valid (1-cycle strobe), freq_ovf / total_ovf (sticky).
// Build option: define PULSE_METER_SAT_EN to saturate total_bcd at all-9s instead of wrapping.
module pulse_meter #(
    parameter int SYNC_STAGES = 2,
    parameter int TOT_DIGITS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pulse_in,
    input  logic                    gate_in,
    input  logic                    count_en,
    input  logic                    clear,
    output logic [4*TOT_DIGITS-1:0] total_bcd,
    output logic [11:0]             freq_bcd,
    output logic                    freq_valid,
    output logic                    freq_ovf,
    output logic                    total_ovf
);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] p_sync, g_sync, e_sync;
    logic                   p_hist, g_hist;
    logic                   pe, ge;
    logic                   en_s;
    logic [11:0]            win_q;

    logic                    tot_inc, win_inc, win_clr, latch;
    logic [4*TOT_DIGITS-1:0] tot_plus;
    logic                    tot_all9;
    logic [11:0]             win_plus, win_sat;
    logic                    win_all9;

    // Synchronisers plus registered edge detectors. Registering pe/ge costs one
    // cycle but keeps the FSM and BCD carry chains off the synchroniser output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_sync <= '0;
            g_sync <= '0;
            e_sync <= '0;
            p_hist <= 1'b0;
            g_hist <= 1'b0;
            pe     <= 1'b0;
            ge     <= 1'b0;
        end else begin
            p_sync <= {p_sync[SYNC_STAGES-2:0], pulse_in};
            g_sync <= {g_sync[SYNC_STAGES-2:0], gate_in};
            e_sync <= {e_sync[SYNC_STAGES-2:0], count_en};
            p_hist <= p_sync[SYNC_STAGES-1];
            g_hist <= g_sync[SYNC_STAGES-1];
            pe     <= p_sync[SYNC_STAGES-1] & ~p_hist;
            ge     <= g_sync[SYNC_STAGES-1] & ~g_hist;
        end
    end

    assign en_s = e_sync[SYNC_STAGES-1];

    // Ripple BCD increment of the total; a carry surviving the top digit means all-9s.
    always_comb begin
        logic c;
        c        = 1'b1;
        tot_plus = total_bcd;
        for (int i = 0; i < TOT_DIGITS; i++) begin
            if (c) begin
                if (total_bcd[4*i +: 4] == 4'd9) begin
                    tot_plus[4*i +: 4] = 4'd0;
                end else begin
                    tot_plus[4*i +: 4] = total_bcd[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        tot_all9 = c;
    end

    // Same chain for the 3-digit window counter, which holds at 999.
    always_comb begin
        logic c;
        c        = 1'b1;
        win_plus = win_q;
        for (int i = 0; i < 3; i++) begin
            if (c) begin
                if (win_q[4*i +: 4] == 4'd9) begin
                    win_plus[4*i +: 4] = 4'd0;
                end else begin
                    win_plus[4*i +: 4] = win_q[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        win_all9 = c;
        win_sat  = c ? win_q : win_plus;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Dropping the enable wins over everything: the open window is discarded
    // and nothing counts or latches in that cycle.
    always_comb begin
        state_d = state_q;
        tot_inc = 1'b0;
        win_inc = 1'b0;
        win_clr = 1'b0;
        latch   = 1'b0;
        if (!en_s) begin
            state_d = IDLE;
            win_clr = 1'b1;
        end else if (clear) begin
            if (state_q == MEASURE) state_d = ARM;
        end else begin
            case (state_q)
                IDLE: begin
                    win_clr = 1'b1;
                    state_d = ARM;
                end
                ARM: begin
                    tot_inc = pe;
                    if (ge) begin
                        win_clr = 1'b1;
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    tot_inc = pe;
                    win_inc = pe;
                    latch   = ge;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_bcd  <= '0;
            freq_bcd   <= '0;
            win_q      <= '0;
            freq_valid <= 1'b0;
            freq_ovf   <= 1'b0;
            total_ovf  <= 1'b0;
        end else if (clear) begin
            total_bcd  <= '0;
            freq_bcd   <= '0;
            win_q      <= '0;
            freq_valid <= 1'b0;
            freq_ovf   <= 1'b0;
            total_ovf  <= 1'b0;
        end else begin
            freq_valid <= latch;
            if (tot_inc) begin
`ifdef PULSE_METER_SAT_EN
                if (tot_all9) total_ovf <= 1'b1;
                else          total_bcd <= tot_plus;
`else
                total_bcd <= tot_plus;
                if (tot_all9) total_ovf <= 1'b1;
`endif
            end
            if (win_inc && win_all9) freq_ovf <= 1'b1;
            // A pulse coinciding with the closing gate edge belongs to the closing window.
            if (latch) begin
                freq_bcd <= win_inc ? win_sat : win_q;
                win_q    <= '0;
            end else if (win_clr) begin
                win_q <= '0;
            end else if (win_inc) begin
                win_q <= win_sat;
            end
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
module tb_pulse_meter;

    localparam int S = 2;

    logic        clk;
    logic        rst;
    logic        pulse_in;
    logic        gate_in;
    logic        count_en;
    logic        clear;
    logic [15:0] total_bcd;
    logic [11:0] freq_bcd;
    logic        freq_valid;
    logic        freq_ovf;
    logic        total_ovf;
    logic [7:0]  total2;
    logic [11:0] freq2;
    logic        fv2;
    logic        fovf2;
    logic        tovf2;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int fv0;
    int tot_model;
    logic [23:0] old_exp;

    logic [23:0] tot_q[$];
    logic [11:0] frq_q[$];

    pulse_meter #(.SYNC_STAGES(S), .TOT_DIGITS(4)) u_dut (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .gate_in(gate_in),
        .count_en(count_en), .clear(clear), .total_bcd(total_bcd),
        .freq_bcd(freq_bcd), .freq_valid(freq_valid), .freq_ovf(freq_ovf),
        .total_ovf(total_ovf)
    );

    pulse_meter #(.SYNC_STAGES(S), .TOT_DIGITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .pulse_in(pulse_in), .gate_in(gate_in),
        .count_en(count_en), .clear(clear), .total_bcd(total2),
        .freq_bcd(freq2), .freq_valid(fv2), .freq_ovf(fovf2),
        .total_ovf(tovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (freq_valid === 1'b1) fv_cnt++;

    function automatic logic [23:0] tobcd(input int v);
        logic [23:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fast_pulses(input int n);
        repeat (n) begin
            pulse_in = 1'b1;
            tick(2);
            pulse_in = 1'b0;
            tick(2);
        end
    endtask

    task automatic gate_edge();
        gate_in = 1'b0;
        tick(3);
        gate_in = 1'b1;
        tick(3);
    endtask

    // Pops the expected window value and waits (bounded) for the strobe.
    task automatic wait_fv(input string tag);
        logic [11:0] e;
        bit got;
        got = 1'b0;
        e = frq_q.pop_front();
        for (int i = 0; i < 40; i++) begin
            if (freq_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            tick(1);
        end
        check({tag, "_vld"}, 24'(got), 24'd1);
        check({tag, "_bcd"}, 24'(freq_bcd), 24'(e));
        tick(1);
        check({tag, "_one"}, 24'(freq_valid), 24'd0);
    endtask

    initial begin
        rst = 1'b0; pulse_in = 1'b0; gate_in = 1'b0; count_en = 1'b0; clear = 1'b0;
        tick(5);
        check("rst_total", 24'(total_bcd), 24'h0);
        check("rst_freq", 24'(freq_bcd), 24'h0);
        check("rst_fv", 24'(freq_valid), 24'h0);
        check("rst_fovf", 24'(freq_ovf), 24'h0);
        check("rst_tovf", 24'(total_ovf), 24'h0);

        // Idle: pulses with the enable low are ignored
        rst = 1'b1;
        tick(5);
        fv0 = fv_cnt;
        fast_pulses(10);
        tick(4);
        check("idle_total", 24'(total_bcd), 24'h0);
        check("idle_freq", 24'(freq_bcd), 24'h0);
        check("idle_fv", 24'(fv_cnt - fv0), 24'h0);

        // Total count with latency check on every pulse (state ARM, total only)
        count_en = 1'b1;
        tick(6);
        tot_model = 0;
        for (int k = 0; k < 37; k++) begin
            old_exp = tobcd(tot_model);
            tot_model++;
            tot_q.push_back(tobcd(tot_model));
            pulse_in = 1'b1;
            tick(S + 1);
            check("lat_early", 24'(total_bcd), old_exp);
            tick(1);
            check("lat_total", 24'(total_bcd), tot_q.pop_front());
            pulse_in = 1'b0;
            tick(4);
        end
        check("total37", 24'(total_bcd), 24'h0037);

        // Window measurement
        gate_edge();
        fast_pulses(23);
        fv0 = fv_cnt;
        frq_q.push_back(12'h023);
        gate_edge();
        wait_fv("win23");
        check("win23_cnt", 24'(fv_cnt - fv0), 24'd1);
        check("win23_total", 24'(total_bcd), 24'h0060);

        // Coincident pulse and gate edge
        gate_in = 1'b0;
        tick(3);
        fast_pulses(4);
        frq_q.push_back(12'h005);
        pulse_in = 1'b1;
        gate_in  = 1'b1;
        tick(2);
        pulse_in = 1'b0;
        tick(2);
        wait_fv("coinc");
        frq_q.push_back(12'h000);
        gate_edge();
        wait_fv("after_coinc");
        check("coinc_total", 24'(total_bcd), 24'h0065);

        // Clear mid-window
        clear = 1'b1; tick(1); clear = 1'b0;
        gate_edge();
        fast_pulses(12);
        tick(2);
        check("pre_clr_total", 24'(total_bcd), 24'h0012);
        clear = 1'b1; tick(1); clear = 1'b0;
        check("clr_total", 24'(total_bcd), 24'h0);
        check("clr_freq", 24'(freq_bcd), 24'h0);
        check("clr_fv", 24'(freq_valid), 24'h0);
        check("clr_fovf", 24'(freq_ovf), 24'h0);
        check("clr_tovf", 24'(total_ovf), 24'h0);
        // After clear the meter is armed: the next gate edge must not latch
        fv0 = fv_cnt;
        fast_pulses(3);
        gate_edge();
        tick(3);
        check("arm_no_latch", 24'(fv_cnt - fv0), 24'h0);
        fast_pulses(4);
        frq_q.push_back(12'h004);
        gate_edge();
        wait_fv("arm_win");

        // Enable dropped mid-window: no latch, freq held
        fast_pulses(2);
        count_en = 1'b0;
        tick(5);
        fv0 = fv_cnt;
        gate_edge();
        tick(5);
        check("endrop_fv", 24'(fv_cnt - fv0), 24'h0);
        check("endrop_freq", 24'(freq_bcd), 24'h004);
        check("endrop_total", 24'(total_bcd), 24'h0009);

        // Window overflow at 999
        count_en = 1'b1;
        tick(6);
        gate_edge();
        fast_pulses(999);
        tick(2);
        check("fovf_999", 24'(freq_ovf), 24'h0);
        fast_pulses(1);
        tick(2);
        check("fovf_1000", 24'(freq_ovf), 24'h1);
        frq_q.push_back(12'h999);
        gate_edge();
        wait_fv("ovf_win");
        check("ovf_total", 24'(total_bcd), 24'h1009);

        // Total overflow on the 2-digit instance
        clear = 1'b1; tick(1); clear = 1'b0;
        check("clr2_fovf", 24'(freq_ovf), 24'h0);
        check("clr2_dut2_freq", 24'(freq2), 24'h0);
        check("clr2_dut2_fv", 24'(fv2), 24'h0);
        check("clr2_dut2_fovf", 24'(fovf2), 24'h0);
        fast_pulses(99);
        tick(2);
        check("tot99", 24'(total2), 24'h99);
        check("tot99_ovf", 24'(tovf2), 24'h0);
        fast_pulses(1);
        tick(2);
`ifdef PULSE_METER_SAT_EN
        check("tot100", 24'(total2), 24'h99);
`else
        check("tot100", 24'(total2), 24'h00);
`endif
        check("tot100_ovf", 24'(tovf2), 24'h1);
        check("main100", 24'(total_bcd), 24'h0100);
        check("main100_ovf", 24'(total_ovf), 24'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
